// File: rtl/psum_gbf_acc.sv
// psum_gbf_acc: partial-sum global buffer with in-place lane-wise accumulation.
// A 2-stage read-modify-write path (capture, then compute + write back) with
// forwarding feeds a DEPTH-entry register array; a drain FSM streams entries
// out over a valid/ready port, optionally clearing each entry as it leaves.
module psum_gbf_acc #(
    parameter int unsigned GBF_DATA_BITWIDTH = 512,
    parameter int unsigned DATA_BITWIDTH     = 16,
    parameter int unsigned GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned DEPTH             = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
    input  logic                         psum_gbf_w_en,
    input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr,
    input  logic                         psum_gbf_w_acc,
    input  logic                         psum_gbf_w_en_for_init,
    input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
    input  logic                         psum_gbf_r_en,
    input  logic [GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
    output logic [GBF_DATA_BITWIDTH-1:0] r_data,
    input  logic                         drain_start,
    input  logic [5:0]                   drain_len,
    input  logic                         drain_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [GBF_DATA_BITWIDTH-1:0] out_data,
    output logic [GBF_ADDR_BITWIDTH-1:0] out_addr,
    output logic                         drain_busy,
    output logic                         drain_done,
    output logic                         wr_drop
);

    localparam int unsigned LANES = GBF_DATA_BITWIDTH / DATA_BITWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [GBF_DATA_BITWIDTH-1:0] arr_q [DEPTH];
    logic [GBF_DATA_BITWIDTH-1:0] arr_d [DEPTH];

    logic                         s0_vld_q, s0_vld_d;
    logic [GBF_ADDR_BITWIDTH-1:0] s0_addr_q, s0_addr_d;
    logic [GBF_DATA_BITWIDTH-1:0] s0_data_q, s0_data_d;
    logic                         s0_acc_q, s0_acc_d;
    logic [GBF_DATA_BITWIDTH-1:0] s0_old_q, s0_old_d;

    logic [GBF_DATA_BITWIDTH-1:0] r_data_q, r_data_d;
    logic [GBF_DATA_BITWIDTH-1:0] out_data_q, out_data_d;
    logic [GBF_ADDR_BITWIDTH-1:0] out_addr_q, out_addr_d;
    logic [5:0]                   rem_q, rem_d;
    logic                         clr_q, clr_d;
    logic                         wr_drop_q, wr_drop_d;

    logic                         busy;
    logic                         wr_take;
    logic                         init_take;
    logic                         handshake;
    logic [GBF_DATA_BITWIDTH-1:0] old_eff;
    logic [GBF_DATA_BITWIDTH-1:0] lane_sum;
    logic [GBF_DATA_BITWIDTH-1:0] wb_res;
    logic [GBF_ADDR_BITWIDTH-1:0] nxt_addr;

    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_SEND);
    assign drain_busy = busy;
    assign drain_done = (state_q == ST_DONE);
    assign wr_drop    = wr_drop_q;
    assign r_data     = r_data_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign handshake  = out_valid && out_ready;
    assign nxt_addr   = out_addr_q + 1'b1;

    // Write-back result of the captured write; an init hitting it zeroes its old word.
    always_comb begin
        wr_take   = psum_gbf_w_en && !busy;
        init_take = psum_gbf_w_en_for_init && !busy;
        old_eff   = s0_old_q;
        if (init_take && s0_vld_q && (psum_gbf_w_addr_for_init == s0_addr_q)) begin
            old_eff = '0;
        end
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum[i*DATA_BITWIDTH +: DATA_BITWIDTH] =
                old_eff[i*DATA_BITWIDTH +: DATA_BITWIDTH] +
                s0_data_q[i*DATA_BITWIDTH +: DATA_BITWIDTH];
        end
        wb_res = s0_acc_q ? lane_sum : s0_data_q;
    end

    // Next array contents: init zero, then write-back, then drain clear.
    // arr_d doubles as the forwarding source for capture, read and drain loads.
    always_comb begin
        arr_d = arr_q;
        if (init_take) begin
            arr_d[psum_gbf_w_addr_for_init] = '0;
        end
        if (s0_vld_q) begin
            arr_d[s0_addr_q] = wb_res;
        end
        if (handshake && clr_q) begin
            arr_d[out_addr_q] = '0;
        end
    end

    // Capture stage and read port.
    always_comb begin
        s0_vld_d  = wr_take;
        s0_addr_d = s0_addr_q;
        s0_data_d = s0_data_q;
        s0_acc_d  = s0_acc_q;
        s0_old_d  = s0_old_q;
        if (wr_take) begin
            s0_addr_d = psum_gbf_w_addr;
            s0_data_d = in_data;
            s0_acc_d  = psum_gbf_w_acc;
            if (init_take && (psum_gbf_w_addr_for_init == psum_gbf_w_addr)) begin
                s0_old_d = '0;
            end else begin
                s0_old_d = arr_d[psum_gbf_w_addr];
            end
        end
        r_data_d  = psum_gbf_r_en ? arr_d[psum_gbf_r_addr] : r_data_q;
        wr_drop_d = busy && (psum_gbf_w_en || psum_gbf_w_en_for_init);
    end

    // Drain FSM next state and beat registers.
    // IDLE jumps straight to SEND when nothing is captured at the start edge,
    // so the first beat appears one cycle after drain_start.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        clr_d      = clr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (drain_start && (drain_len != '0)) begin
                    rem_d = drain_len;
                    clr_d = drain_clr;
                    if (!s0_vld_d) begin
                        state_d    = ST_SEND;
                        out_addr_d = '0;
                        out_data_d = arr_d[0];
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!s0_vld_d) begin
                    state_d    = ST_SEND;
                    out_addr_d = '0;
                    out_data_d = arr_d[0];
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (rem_q == 6'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d      = rem_q - 6'd1;
                        out_addr_d = nxt_addr;
                        out_data_d = arr_d[nxt_addr];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                arr_q[i] <= '0;
            end
            s0_vld_q   <= 1'b0;
            s0_addr_q  <= '0;
            s0_data_q  <= '0;
            s0_acc_q   <= 1'b0;
            s0_old_q   <= '0;
            r_data_q   <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            rem_q      <= '0;
            clr_q      <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            arr_q      <= arr_d;
            s0_vld_q   <= s0_vld_d;
            s0_addr_q  <= s0_addr_d;
            s0_data_q  <= s0_data_d;
            s0_acc_q   <= s0_acc_d;
            s0_old_q   <= s0_old_d;
            r_data_q   <= r_data_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            rem_q      <= rem_d;
            clr_q      <= clr_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

endmodule

// File: tb/tb_psum_gbf_acc.sv
// Testbench for psum_gbf_acc: directed vectors, scoreboard queues for read
// data and drain beats, and a decoupled monitor that pops and compares.
module tb_psum_gbf_acc;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] in_data;
    logic         psum_gbf_w_en;
    logic [4:0]   psum_gbf_w_addr;
    logic         psum_gbf_w_acc;
    logic         psum_gbf_w_en_for_init;
    logic [4:0]   psum_gbf_w_addr_for_init;
    logic         psum_gbf_r_en;
    logic [4:0]   psum_gbf_r_addr;
    logic [511:0] r_data;
    logic         drain_start;
    logic [5:0]   drain_len;
    logic         drain_clr;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [4:0]   out_addr;
    logic         drain_busy;
    logic         drain_done;
    logic         wr_drop;

    typedef struct {
        logic [4:0]   a;
        logic [511:0] d;
    } beat_t;

    logic [511:0] exp_rd[$];
    beat_t        exp_beat[$];
    int           checks = 0;
    int           errors = 0;

    psum_gbf_acc #(
        .GBF_DATA_BITWIDTH(512),
        .DATA_BITWIDTH(16),
        .GBF_ADDR_BITWIDTH(5),
        .DEPTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .psum_gbf_w_en(psum_gbf_w_en),
        .psum_gbf_w_addr(psum_gbf_w_addr),
        .psum_gbf_w_acc(psum_gbf_w_acc),
        .psum_gbf_w_en_for_init(psum_gbf_w_en_for_init),
        .psum_gbf_w_addr_for_init(psum_gbf_w_addr_for_init),
        .psum_gbf_r_en(psum_gbf_r_en),
        .psum_gbf_r_addr(psum_gbf_r_addr),
        .r_data(r_data),
        .drain_start(drain_start),
        .drain_len(drain_len),
        .drain_clr(drain_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .drain_busy(drain_busy),
        .drain_done(drain_done),
        .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] rep(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [511:0] d, input logic acc);
        psum_gbf_w_en = 1'b1; psum_gbf_w_addr = a; in_data = d; psum_gbf_w_acc = acc;
        tick();
        psum_gbf_w_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [511:0] exp);
        psum_gbf_r_en = 1'b1; psum_gbf_r_addr = a;
        exp_rd.push_back(exp);
        tick();
        psum_gbf_r_en = 1'b0;
    endtask

    task automatic push_beat(input logic [4:0] a, input logic [511:0] d);
        beat_t b;
        b.a = a; b.d = d;
        exp_beat.push_back(b);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!drain_done && n < 40) begin
            tick();
            n++;
        end
        chk("drain_done_seen", {511'd0, drain_done}, 512'd1);
    endtask

    // Monitor: sample handshakes just before the edge, compare just after it.
    initial begin : monitor
        logic         rd_fire;
        logic         hs;
        logic [4:0]   hs_addr;
        logic [511:0] hs_data;
        logic [511:0] e;
        beat_t        b;
        forever begin
            @(negedge clk);
            #4;
            rd_fire = psum_gbf_r_en;
            hs      = out_valid && out_ready;
            hs_addr = out_addr;
            hs_data = out_data;
            @(posedge clk);
            #1;
            if (rd_fire) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 512'd1, 512'd0);
                end else begin
                    e = exp_rd.pop_front();
                    chk("r_data", r_data, e);
                end
            end
            if (hs) begin
                if (exp_beat.size() == 0) begin
                    chk("beat_unexpected", 512'd1, 512'd0);
                end else begin
                    b = exp_beat.pop_front();
                    chk("beat_addr", {507'd0, hs_addr}, {507'd0, b.a});
                    chk("beat_data", hs_data, b.d);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b0;
        in_data = '0; psum_gbf_w_en = 0; psum_gbf_w_addr = '0; psum_gbf_w_acc = 0;
        psum_gbf_w_en_for_init = 0; psum_gbf_w_addr_for_init = '0;
        psum_gbf_r_en = 0; psum_gbf_r_addr = '0;
        drain_start = 0; drain_len = '0; drain_clr = 0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_r_data", r_data, '0);
        chk("rst_out_valid", {511'd0, out_valid}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_addr", {507'd0, out_addr}, '0);
        chk("rst_busy", {511'd0, drain_busy}, '0);
        chk("rst_done", {511'd0, drain_done}, '0);
        chk("rst_wr_drop", {511'd0, wr_drop}, '0);
        reset = 1'b1;
        tick();

        // Back-to-back accumulate to addr 3 (forwarding)
        wr(5'd3, rep(16'h0001), 1'b1);
        wr(5'd3, rep(16'h0001), 1'b1);
        rd(5'd3, rep(16'h0002));

        // Overwrite and lane wrap on addr 7
        wr(5'd7, rep(16'h0003), 1'b0);
        wr(5'd7, rep(16'h0005), 1'b0);
        rd(5'd7, rep(16'h0005));
        wr(5'd7, rep(16'hFFFF), 1'b1);
        rd(5'd7, rep(16'h0004));

        // Init and acc write to the same address on the same cycle
        wr(5'd2, rep(16'h0009), 1'b0);
        psum_gbf_w_en_for_init = 1'b1; psum_gbf_w_addr_for_init = 5'd2;
        wr(5'd2, rep(16'h0003), 1'b1);
        psum_gbf_w_en_for_init = 1'b0;
        rd(5'd2, rep(16'h0003));

        // Init to 4 alongside acc write to 5
        wr(5'd4, rep(16'h0008), 1'b0);
        wr(5'd5, rep(16'h0001), 1'b0);
        psum_gbf_w_en_for_init = 1'b1; psum_gbf_w_addr_for_init = 5'd4;
        wr(5'd5, rep(16'h0006), 1'b1);
        psum_gbf_w_en_for_init = 1'b0;
        rd(5'd4, rep(16'h0000));
        rd(5'd5, rep(16'h0007));

        // Drain 4 entries with clear and one stall cycle
        for (int i = 0; i < 4; i++) wr(i[4:0], rep(16'(i + 1)), 1'b0);
        tick();
        for (int i = 0; i < 4; i++) push_beat(i[4:0], rep(16'(i + 1)));
        drain_start = 1'b1; drain_len = 6'd4; drain_clr = 1'b1; out_ready = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("first_beat_valid", {511'd0, out_valid}, 512'd1);
        chk("first_beat_addr", {507'd0, out_addr}, 512'd0);
        chk("busy_during", {511'd0, drain_busy}, 512'd1);
        tick();
        out_ready = 1'b0;
        chk("pre_stall_addr", {507'd0, out_addr}, 512'd1);
        tick();
        chk("stall_addr_hold", {507'd0, out_addr}, 512'd1);
        chk("stall_data_hold", out_data, rep(16'h0002));
        out_ready = 1'b1;
        tick();
        tick();
        chk("done_not_early", {511'd0, drain_done}, 512'd0);
        tick();
        chk("done_pulse", {511'd0, drain_done}, 512'd1);
        chk("busy_in_done", {511'd0, drain_busy}, 512'd1);
        tick();
        chk("done_cleared", {511'd0, drain_done}, 512'd0);
        chk("busy_cleared", {511'd0, drain_busy}, 512'd0);
        for (int i = 0; i < 4; i++) rd(i[4:0], '0);

        // Write dropped while busy
        wr(5'd9, rep(16'h0011), 1'b0);
        push_beat(5'd0, '0);
        push_beat(5'd1, '0);
        out_ready = 1'b0;
        drain_start = 1'b1; drain_len = 6'd2; drain_clr = 1'b0;
        tick();
        drain_start = 1'b0;
        wr(5'd9, rep(16'h0077), 1'b0);
        chk("wr_drop_pulse", {511'd0, wr_drop}, 512'd1);
        tick();
        chk("wr_drop_once", {511'd0, wr_drop}, 512'd0);
        out_ready = 1'b1;
        wait_done();
        tick();
        rd(5'd9, rep(16'h0011));

        // Drain issued one cycle after a write
        wr(5'd0, rep(16'h0005), 1'b0);
        wr(5'd0, rep(16'h002A), 1'b1);
        push_beat(5'd0, rep(16'h002F));
        drain_start = 1'b1; drain_len = 6'd1; drain_clr = 1'b0;
        tick();
        drain_start = 1'b0;
        wait_done();
        tick();

        // Drain issued on the same cycle as a write (waits for the pipeline)
        push_beat(5'd0, rep(16'h0030));
        drain_start = 1'b1; drain_len = 6'd1; drain_clr = 1'b0;
        wr(5'd0, rep(16'h0001), 1'b1);
        drain_start = 1'b0;
        wait_done();
        tick();

        // Reset asserted mid-drain while beat 2 is presented
        for (int i = 0; i < 4; i++) wr(i[4:0], rep(16'(16'h0010 + i)), 1'b0);
        tick();
        push_beat(5'd0, rep(16'h0010));
        push_beat(5'd1, rep(16'h0011));
        drain_start = 1'b1; drain_len = 6'd4; drain_clr = 1'b0;
        tick();
        drain_start = 1'b0;
        tick();
        tick();
        chk("beat2_presented", {507'd0, out_addr}, 512'd2);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", {511'd0, out_valid}, '0);
        chk("rst_mid_busy", {511'd0, drain_busy}, '0);
        chk("rst_mid_addr", {507'd0, out_addr}, '0);
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) rd(i[4:0], '0);
        rd(5'd9, '0);
        rd(5'd7, '0);

        repeat (3) tick();
        chk("rd_queue_empty", 512'(exp_rd.size()), '0);
        chk("beat_queue_empty", 512'(exp_beat.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
